addsub_multicycle: RTL and testbench
====================================

ADDSUB_MULTICYCLE -- requirements
Module: addsub_multicycle

Interface
REQ-001 The module SHALL use one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameter WIDTH, default 8: operand and result width in bits.
REQ-003 Parameter CHUNK, default 4: bits processed per cycle; WIDTH % CHUNK == 0 and CHUNK >= 1, checked at elaboration.
REQ-004 Ports SHALL be exactly as follows:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operands and control are valid.
- in_ready  out  1  unit can accept an operation.
- a  in  WIDTH  minuend or first addend.
- b  in  WIDTH  subtrahend or second addend.
- op  in  1  0 = add, 1 = subtract.
- use_cin  in  1  1 = use cin instead of the default carry-in.
- cin  in  1  external carry-in for chained multi-word operations.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  sum or difference, modulo 2^WIDTH.
- cout  out  1  final carry; in subtract mode, 1 = no borrow.
- ovf  out  1  signed two's-complement overflow.
- zero  out  1  result == 0.
- neg  out  1  result[WIDTH-1].

Function
REQ-005 Arithmetic: result = a + (op ? ~b : b) + c0, where c0 = use_cin ? cin : op.
REQ-006 The carry chain SHALL be computed CHUNK bits per cycle, LSB chunk first. An internal carry register holds the carry between chunks.
REQ-007 State machine states SHALL be IDLE, BUSY and DONE.
- IDLE -> BUSY on in_valid && in_ready.
- BUSY -> DONE after the last chunk.
- DONE -> IDLE on out_ready.
REQ-008 in_ready SHALL be 1 only in IDLE. out_valid SHALL be 1 only in DONE.
REQ-009 On accept, a, b (already inverted if op = 1) and c0 SHALL be captured. Later changes on the input ports SHALL NOT affect the operation in flight.
REQ-010 Latency: an operation accepted at edge N SHALL assert out_valid from edge N + WIDTH/CHUNK.
REQ-011 Boundary case CHUNK == WIDTH: one BUSY cycle.
REQ-012 The result SHALL be assembled in a shift or indexed register. Chunk k SHALL be written to bits [k*CHUNK +: CHUNK].
REQ-013 cout SHALL be the carry out of the MSB chunk.
REQ-014 ovf SHALL be the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1, captured during the MSB chunk.
REQ-015 zero and neg SHALL be derived from the final result and registered.
REQ-016 result, cout, ovf, zero and neg SHALL be held stable while out_valid && !out_ready, for any length of stall.
REQ-017 The handshake rules SHALL be:
- No new operation is accepted in the cycle the result is consumed; the minimum issue interval is WIDTH/CHUNK + 2 cycles.
- in_valid while not IDLE is ignored and not queued.
REQ-018 Wrap-around: results SHALL be modulo 2^WIDTH with no saturation.
- 0 - 1 yields all ones, cout = 0.
- All ones + 1 yields 0, cout = 1, zero = 1.
REQ-019 Chaining: a multi-word operation issued as successive operations, with cin = the previous cout and use_cin = 1, SHALL produce correct multi-word add and subtract results.

Reset
REQ-020 On rst, the state SHALL go to IDLE on the same edge. in_ready SHALL be 1 and out_valid SHALL be 0 in the following cycle.
REQ-021 On rst, result, cout, ovf, zero, neg, the internal carry and the chunk counter SHALL all be 0.
REQ-022 Reset asserted in BUSY or DONE SHALL abort the operation. No out_valid pulse SHALL be produced for the aborted operation.
REQ-023 rst SHALL take priority over in_valid and out_ready in the same cycle.

Structure
REQ-024 A shared package addsub_pkg SHALL hold:
- the op encoding constants OP_ADD = 0 and OP_SUB = 1;
- the state enum (IDLE, BUSY, DONE).
REQ-025 One combinational sub-module, addsub_chunk (CHUNK-bit adder), SHALL be instantiated once. It has inputs x, y, ci and outputs s, co, and c_msb_in (the carry into its top bit, used for ovf).
REQ-026 The chunk counter width SHALL be $clog2(WIDTH/CHUNK), minimum 1.

Verification
Directed scenarios, WIDTH = 8 and CHUNK = 4 unless stated:
REQ-027 sub 0x05 - 0x03 -> result = 0x02, cout = 1, ovf = 0, zero = 0, neg = 0; out_valid exactly 2 cycles after accept.
REQ-028 sub 0x03 - 0x05 -> result = 0xFE, cout = 0, neg = 1. sub 0x80 - 0x01 -> result = 0x7F, ovf = 1.
REQ-029 add 0x7F + 0x01 -> result = 0x80, ovf = 1, neg = 1. add 0xFF + 0x01 -> result = 0x00, cout = 1, zero = 1.
REQ-030 Chained 16-bit subtract 0x0100 - 0x0001 done as two ops:
- low byte: 0x00 - 0x01 -> 0xFF, cout = 0;
- high byte: 0x01 - 0x00 with use_cin = 1, cin = 0 -> 0x00;
- combined result 0x00FF.
REQ-031 Hold out_ready = 0 for 5 cycles in DONE -> outputs stable and in_ready = 0 throughout. Toggling a and b during BUSY -> result unchanged.
REQ-032 Assert rst mid-BUSY -> next cycle IDLE, all outputs 0, no out_valid. Repeat REQ-027 with CHUNK = 1 (latency 8) and CHUNK = 8 (latency 1).

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared constants and state encoding for the multi-cycle add/subtract unit.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/addsub_chunk.sv
// Combinational W-bit adder slice; also exposes the carry into its top bit
// so the caller can form signed overflow on the most significant slice.
module addsub_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb_in
);

    logic [W:0] w_sum;

    assign w_sum    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    assign s        = w_sum[W-1:0];
    assign co       = w_sum[W];
    // sum bit = x ^ y ^ carry_in, so the carry into the top bit falls out directly
    assign c_msb_in = x[W-1] ^ y[W-1] ^ w_sum[W-1];

endmodule

// File: rtl/addsub_multicycle.sv
// Multi-cycle adder/subtractor: the carry chain is walked CHUNK bits per
// cycle, LSB chunk first, with a valid/ready handshake on both sides.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready high
// BUSY  | one chunk of the carry chain per cycle
// DONE  | result and flags presented, held until out_ready
module addsub_multicycle
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    input  logic             use_cin,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int NCHUNK = WIDTH / ((CHUNK < 1) ? 1 : CHUNK);
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
        $error("addsub_multicycle: CHUNK must be >= 1 and divide WIDTH");
    end

    state_t            r_state;
    state_t            w_state_next;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_result;
    logic [WIDTH-1:0]  w_result_next;
    logic              r_carry;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_cout;
    logic              r_ovf;
    logic              r_zero;
    logic              r_neg;
    logic [CHUNK-1:0]  w_x;
    logic [CHUNK-1:0]  w_y;
    logic [CHUNK-1:0]  w_s;
    logic              w_co;
    logic              w_c_msb_in;
    logic              w_last;
    logic              w_accept;
    int                w_base;

    assign w_base   = int'(r_cnt) * CHUNK;
    assign w_x      = r_a[w_base +: CHUNK];
    assign w_y      = r_b[w_base +: CHUNK];
    assign w_last   = (r_cnt == LAST_CNT);
    assign w_accept = in_valid && (r_state == IDLE);

    addsub_chunk #(.W(CHUNK)) u_chunk (
        .x        (w_x),
        .y        (w_y),
        .ci       (r_carry),
        .s        (w_s),
        .co       (w_co),
        .c_msb_in (w_c_msb_in)
    );

    // result with the current chunk merged in; on the last chunk this is the final value
    always_comb begin
        w_result_next = r_result;
        w_result_next[w_base +: CHUNK] = w_s;
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // next-state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = BUSY;
            end
            BUSY: begin
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // operand capture on accept, then one chunk per BUSY cycle; flags land with the MSB chunk
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= (op == OP_SUB) ? ~b : b;
            r_carry <= use_cin ? cin : (op == OP_SUB);
            r_cnt   <= '0;
        end else if (r_state == BUSY) begin
            r_result <= w_result_next;
            r_carry  <= w_co;
            if (w_last) begin
                r_cout <= w_co;
                r_ovf  <= w_c_msb_in ^ w_co;
                r_zero <= (w_result_next == '0);
                r_neg  <= w_result_next[WIDTH-1];
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign result = r_result;
    assign cout   = r_cout;
    assign ovf    = r_ovf;
    assign zero   = r_zero;
    assign neg    = r_neg;

endmodule

// File: tb/tb_addsub_multicycle.sv
// Scoreboard bench: three instances (CHUNK = 4, 1, 8) receive the same
// operations; each lane has its own monitor popping expected responses.
module tb_addsub_multicycle;

    localparam int W  = 8;
    localparam int NL = 3;

    typedef struct {
        logic [7:0] r;
        logic       co;
        logic       ov;
        logic       z;
        logic       n;
        int         acc;
    } exp_t;

    typedef struct {
        logic       o;
        logic [7:0] x;
        logic [7:0] y;
        logic       uc;
        logic       ci;
        logic       stall5;
        logic [7:0] r;
        logic       co;
    } dir_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic       op;
    logic       use_cin;
    logic       cin;

    logic       in_ready_v  [NL];
    logic       out_valid_v [NL];
    logic       out_ready_v [NL];
    logic [7:0] result_v    [NL];
    logic       cout_v      [NL];
    logic       ovf_v       [NL];
    logic       zero_v      [NL];
    logic       neg_v       [NL];

    exp_t       sb [NL][$];
    logic [7:0] last_res [NL];
    logic       last_co  [NL];
    logic       force_stall = 1'b0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference: plain integer add, or subtract-with-borrow where c0 = 1 means no borrow
    function automatic exp_t model(input logic o, input logic [7:0] x, input logic [7:0] y,
                                   input logic uc, input logic ci);
        exp_t e;
        int c0, xi, yi, sx, sy, s, ss;
        c0 = uc ? int'(ci) : int'(o);
        xi = int'(x);
        yi = int'(y);
        sx = (xi >= 128) ? xi - 256 : xi;
        sy = (yi >= 128) ? yi - 256 : yi;
        if (!o) begin
            s  = xi + yi + c0;
            ss = sx + sy + c0;
            e.co = (s >= 256);
        end else begin
            s  = xi - yi - (1 - c0);
            ss = sx - sy - (1 - c0);
            e.co = (s >= 0);
        end
        e.r   = 8'((s + 256) % 256);
        e.ov  = (ss > 127) || (ss < -128);
        e.z   = (e.r == 8'h00);
        e.n   = e.r[7];
        e.acc = 0;
        return e;
    endfunction

    function automatic logic all_idle();
        return in_ready_v[0] && in_ready_v[1] && in_ready_v[2];
    endfunction

    function automatic logic all_empty();
        return (sb[0].size() == 0) && (sb[1].size() == 0) && (sb[2].size() == 0);
    endfunction

    for (genvar g = 0; g < NL; g++) begin : g_lane
        localparam int LCH = (g == 0) ? 4 : ((g == 1) ? 1 : 8);

        addsub_multicycle #(.WIDTH(W), .CHUNK(LCH)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready_v[g]),
            .a         (a),
            .b         (b),
            .op        (op),
            .use_cin   (use_cin),
            .cin       (cin),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready_v[g]),
            .result    (result_v[g]),
            .cout      (cout_v[g]),
            .ovf       (ovf_v[g]),
            .zero      (zero_v[g]),
            .neg       (neg_v[g])
        );

        initial begin : mon
            logic prev_v;
            int   stall;
            exp_t e;
            prev_v = 1'b0;
            stall  = 0;
            out_ready_v[g] = 1'b0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    prev_v = 1'b0;
                    out_ready_v[g] = 1'b0;
                end else if (out_valid_v[g]) begin
                    if (!prev_v) begin
                        if (sb[g].size() == 0) begin
                            fail_now($sformatf("spurious_out_valid lane%0d", g));
                        end else begin
                            e = sb[g].pop_front();
                            chk($sformatf("latency_l%0d", g), cyc - e.acc, W / LCH);
                            last_res[g] = result_v[g];
                            last_co[g]  = cout_v[g];
                        end
                        stall = force_stall ? 5 : $urandom_range(0, 2);
                    end else begin
                        chk($sformatf("stall_in_ready_l%0d", g), in_ready_v[g], 1'b0);
                    end
                    chk($sformatf("result_l%0d", g), result_v[g], e.r);
                    chk($sformatf("cout_l%0d", g), cout_v[g], e.co);
                    chk($sformatf("ovf_l%0d", g), ovf_v[g], e.ov);
                    chk($sformatf("zero_l%0d", g), zero_v[g], e.z);
                    chk($sformatf("neg_l%0d", g), neg_v[g], e.n);
                    out_ready_v[g] = (stall == 0);
                    if (stall > 0) stall--;
                    prev_v = 1'b1;
                end else begin
                    prev_v = 1'b0;
                    out_ready_v[g] = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    // Issue one op to all lanes, then poke in_valid during BUSY (must be ignored)
    task automatic issue(input logic o, input logic [7:0] x, input logic [7:0] y,
                         input logic uc, input logic ci, input logic stall5);
        exp_t e;
        int t;
        t = 0;
        @(negedge clk);
        while (!all_idle() && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) fail_now("timeout_wait_idle");
        force_stall = stall5;
        a = x; b = y; op = o; use_cin = uc; cin = ci;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        e = model(o, x, y, uc, ci);
        e.acc = cyc;
        for (int l = 0; l < NL; l++) sb[l].push_back(e);
        in_valid = 1'b0;
        @(negedge clk);
        a = 8'($urandom); b = 8'($urandom);
        op = 1'($urandom); use_cin = 1'($urandom); cin = 1'($urandom);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            a = 8'($urandom);
            b = 8'($urandom);
            t++;
        end while (!(all_idle() && all_empty()) && t < 300);
        if (t >= 300) fail_now("timeout_wait_done");
    endtask

    task automatic check_idle_zero(input string tag);
        for (int l = 0; l < NL; l++) begin
            chk($sformatf("%s_in_ready_l%0d", tag, l), in_ready_v[l], 1'b1);
            chk($sformatf("%s_out_valid_l%0d", tag, l), out_valid_v[l], 1'b0);
            chk($sformatf("%s_result_l%0d", tag, l), result_v[l], 8'h00);
            chk($sformatf("%s_flags_l%0d", tag, l),
                {cout_v[l], ovf_v[l], zero_v[l], neg_v[l]}, 4'b0000);
        end
    endtask

    task automatic chain16(input logic o, input logic [15:0] x, input logic [15:0] y);
        logic [7:0]  lo;
        logic [15:0] exp16;
        issue(o, x[7:0], y[7:0], 1'b0, 1'b0, 1'b0);
        wait_done();
        lo = last_res[0];
        issue(o, x[15:8], y[15:8], 1'b1, last_co[0], 1'b0);
        wait_done();
        exp16 = o ? (x - y) : (x + y);
        chk($sformatf("chain16_%0h_%s_%0h", x, o ? "sub" : "add", y), {last_res[0], lo}, exp16);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin : main
        dir_t dir [8];
        dir[0] = '{1'b1, 8'h05, 8'h03, 1'b0, 1'b0, 1'b0, 8'h02, 1'b1};
        dir[1] = '{1'b1, 8'h03, 8'h05, 1'b0, 1'b0, 1'b0, 8'hFE, 1'b0};
        dir[2] = '{1'b1, 8'h80, 8'h01, 1'b0, 1'b0, 1'b0, 8'h7F, 1'b1};
        dir[3] = '{1'b0, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0};
        dir[4] = '{1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
        dir[5] = '{1'b1, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0};
        dir[6] = '{1'b1, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
        dir[7] = '{1'b0, 8'h12, 8'h34, 1'b0, 1'b0, 1'b1, 8'h46, 1'b0};

        rst = 1'b1; in_valid = 1'b0;
        a = '0; b = '0; op = 1'b0; use_cin = 1'b0; cin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;

        foreach (dir[i]) begin
            issue(dir[i].o, dir[i].x, dir[i].y, dir[i].uc, dir[i].ci, dir[i].stall5);
            wait_done();
            for (int l = 0; l < NL; l++) begin
                chk($sformatf("dir%0d_result_l%0d", i, l), last_res[l], dir[i].r);
                chk($sformatf("dir%0d_cout_l%0d", i, l), last_co[l], dir[i].co);
            end
        end

        chain16(1'b1, 16'h0100, 16'h0001);
        for (int i = 0; i < 8; i++) begin
            chain16(1'($urandom), 16'($urandom), 16'($urandom));
        end

        for (int i = 0; i < 60; i++) begin
            issue(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 7) == 0));
        end
        wait_done();

        // Abort: accept an op, reset while every lane is still BUSY
        @(negedge clk);
        a = 8'h05; b = 8'h03; op = 1'b1; use_cin = 1'b0; cin = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check_idle_zero("abort");
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            for (int l = 0; l < NL; l++)
                chk($sformatf("abort_no_valid_l%0d", l), out_valid_v[l], 1'b0);
        end

        issue(1'b1, 8'h05, 8'h03, 1'b0, 1'b0, 1'b0);
        wait_done();
        for (int l = 0; l < NL; l++)
            chk($sformatf("post_abort_result_l%0d", l), last_res[l], 8'h02);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
